// File: rtl/rtc_bus_sequencer_pkg.sv
// Shared definitions for the RTC multiplexed-bus sequencer: FSM states,
// default phase timings and the pin-bundle type driven toward the chip.
package rtc_bus_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_HOLD  = 3'd2,
        ST_DATA  = 3'd3,
        ST_RECOV = 3'd4
    } state_t;

    localparam int T_ADDR_DEF   = 4;
    localparam int T_HOLD_DEF   = 2;
    localparam int T_STROBE_DEF = 6;
    localparam int T_RECOV_DEF  = 3;
    localparam int CNT_W_DEF    = 4;

    typedef struct packed {
        logic       a_d;
        logic       cs;
        logic       rd;
        logic       wr;
        logic       oe;
        logic [7:0] rtc_in;
    } pins_t;

    localparam pins_t PINS_IDLE = '{a_d: 1'b1, cs: 1'b1, rd: 1'b1, wr: 1'b1, oe: 1'b0, rtc_in: 8'h00};

    // Pin levels that belong to a given state; strobes only ever drop in DATA,
    // where A_D is already high, and a read never enables the bus driver.
    function automatic pins_t pins_for(state_t s, logic we, logic [7:0] addr, logic [7:0] wdata);
        pins_t p;
        p = PINS_IDLE;
        case (s)
            ST_ADDR: begin
                p.a_d    = 1'b0;
                p.cs     = 1'b0;
                p.oe     = 1'b1;
                p.rtc_in = addr;
            end
            ST_HOLD: begin
                p.cs     = 1'b0;
                p.oe     = 1'b1;
                p.rtc_in = addr;
            end
            ST_DATA: begin
                p.cs = 1'b0;
                if (we) begin
                    p.wr     = 1'b0;
                    p.oe     = 1'b1;
                    p.rtc_in = wdata;
                end else begin
                    p.rd = 1'b0;
                end
            end
            default: p = PINS_IDLE;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/rtc_bus_sequencer.sv
// Runs one multiplexed address/data bus cycle to the external RTC chip per
// request; every pin and status output comes straight from a flop.
module rtc_bus_sequencer
    import rtc_bus_sequencer_pkg::*;
#(
    parameter int T_ADDR   = T_ADDR_DEF,
    parameter int T_HOLD   = T_HOLD_DEF,
    parameter int T_STROBE = T_STROBE_DEF,
    parameter int T_RECOV  = T_RECOV_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic       we,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       A_D,
    output logic       CS,
    output logic       RD,
    output logic       WR,
    output logic       bus_oe,
    output logic [7:0] RTC_in,
    input  logic [7:0] RTC_out
);

    // Handshake: req is taken only while the sequencer is in IDLE (including the
    // cycle done is high); busy covers acceptance to completion, requests seen
    // while busy are dropped, and done pulses for exactly one cycle.

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             we_q, we_nxt;
    logic [7:0]       addr_q, addr_nxt, wdata_q, wdata_nxt;
    logic             done_nxt, rd_sample;
    pins_t            pins_q, pins_nxt;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        we_nxt    = we_q;
        addr_nxt  = addr_q;
        wdata_nxt = wdata_q;
        done_nxt  = 1'b0;
        rd_sample = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    state_nxt = ST_ADDR;
                    cnt_nxt   = CNT_W'(T_ADDR - 1);
                    we_nxt    = we;
                    addr_nxt  = addr;
                    wdata_nxt = wdata;
                end
            end
            ST_ADDR: begin
                if (cnt == '0) begin
                    state_nxt = ST_HOLD;
                    cnt_nxt   = CNT_W'(T_HOLD - 1);
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (cnt == '0) begin
                    state_nxt = ST_DATA;
                    cnt_nxt   = CNT_W'(T_STROBE - 1);
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (cnt == '0) begin
                    // Chip data is only trusted on the edge closing the strobe.
                    state_nxt = ST_RECOV;
                    cnt_nxt   = CNT_W'(T_RECOV - 1);
                    rd_sample = ~we_q;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            ST_RECOV: begin
                if (cnt == '0) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                    done_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
        pins_nxt = pins_for(state_nxt, we_nxt, addr_nxt, wdata_nxt);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            we_q    <= 1'b0;
            addr_q  <= 8'h00;
            wdata_q <= 8'h00;
            pins_q  <= PINS_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            rdata   <= 8'h00;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            we_q    <= we_nxt;
            addr_q  <= addr_nxt;
            wdata_q <= wdata_nxt;
            pins_q  <= pins_nxt;
            busy    <= (state_nxt != ST_IDLE);
            done    <= done_nxt;
            if (rd_sample) begin
                rdata <= RTC_out;
            end
        end
    end

    assign A_D    = pins_q.a_d;
    assign CS     = pins_q.cs;
    assign RD     = pins_q.rd;
    assign WR     = pins_q.wr;
    assign bus_oe = pins_q.oe;
    assign RTC_in = pins_q.rtc_in;

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Self-checking bench for rtc_bus_sequencer: table-driven transactions, hand
// sequences for reset/back-to-back/ignored requests, then random transactions.
module tb_rtc_bus_sequencer;

    localparam int TA    = 4;
    localparam int TH    = 2;
    localparam int TS    = 6;
    localparam int TR    = 3;
    localparam int TOTAL = TA + TH + TS + TR;
    localparam int NRAND = 24;

    logic       clk;
    logic       reset;
    logic       req;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       busy;
    logic       done;
    logic [7:0] rdata;
    logic       A_D;
    logic       CS;
    logic       RD;
    logic       WR;
    logic       bus_oe;
    logic [7:0] RTC_in;
    logic [7:0] RTC_out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rf;   // chip byte in the last strobe cycle
        logic [7:0] re;   // chip byte in the earlier strobe cycles
    } txn_t;

    typedef struct {
        txn_t       t;
        logic [7:0] exp_rdata;
    } vec_t;

    typedef struct packed {
        logic       a_d;
        logic       cs;
        logic       rd;
        logic       wr;
        logic       oe;
        logic [7:0] rtc_in;
        logic       busy;
        logic       done;
    } bus_t;

    logic [7:0] exp_q[$];
    logic [7:0] rd_model;
    vec_t       vecs[4];
    txn_t       rtx[NRAND];

    rtc_bus_sequencer dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .we      (we),
        .addr    (addr),
        .wdata   (wdata),
        .busy    (busy),
        .done    (done),
        .rdata   (rdata),
        .A_D     (A_D),
        .CS      (CS),
        .RD      (RD),
        .WR      (WR),
        .bus_oe  (bus_oe),
        .RTC_in  (RTC_in),
        .RTC_out (RTC_out)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    // ---------------- reference: pin levels k cycles after acceptance -------
    function automatic bus_t exp_bus(int k, txn_t t);
        bus_t b;
        b = '{a_d: 1'b1, cs: 1'b1, rd: 1'b1, wr: 1'b1, oe: 1'b0, rtc_in: 8'h00, busy: 1'b1, done: 1'b0};
        if (k <= TA) begin
            b.a_d = 1'b0; b.cs = 1'b0; b.oe = 1'b1; b.rtc_in = t.addr;
        end else if (k <= TA + TH) begin
            b.cs = 1'b0; b.oe = 1'b1; b.rtc_in = t.addr;
        end else if (k <= TA + TH + TS) begin
            b.cs = 1'b0;
            if (t.we) begin
                b.wr = 1'b0; b.oe = 1'b1; b.rtc_in = t.wdata;
            end else begin
                b.rd = 1'b0;
            end
        end else if (k > TOTAL) begin
            b.busy = 1'b0; b.done = 1'b1;
        end
        return b;
    endfunction

    function automatic bus_t act_bus();
        bus_t b;
        b = '{a_d: A_D, cs: CS, rd: RD, wr: WR, oe: bus_oe, rtc_in: RTC_in, busy: busy, done: done};
        return b;
    endfunction

    // ---------------- scoreboard helpers ----------------
    task automatic check_bus(input string name, input bus_t exp_b);
        bus_t a;
        a = act_bus();
        if (!exp_b.oe) begin
            a.rtc_in     = 8'h00;
            exp_b.rtc_in = 8'h00;
        end
        checks++;
        if (a !== exp_b) begin
            errors++;
            $display("FAIL %s: got {A_D,CS,RD,WR,oe,RTC_in,busy,done}=%b required %b at %0t",
                     name, a, exp_b, $time);
        end
    endtask

    task automatic check_val(input string name, input logic [7:0] act, input logic [7:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h required %h at %0t", name, act, exp_v, $time);
        end
    endtask

    // ---------------- drivers ----------------
    // Called at posedge+1; leaves the bench at posedge+1 of the first busy cycle.
    task automatic launch(input txn_t t);
        req   = 1'b1;
        we    = t.we;
        addr  = t.addr;
        wdata = t.wdata;
        @(posedge clk);
        #1;
        req = 1'b0;
    endtask

    // Walks one accepted transaction through to its done cycle, checking every cycle.
    task automatic run_body(input string name, input txn_t t, input logic [7:0] exp_rd,
                            input bit pulse, input bit chain, input txn_t nt);
        for (int k = 1; k <= TOTAL + 1; k++) begin
            if (k > TA + TH && k <= TA + TH + TS)
                RTC_out = (k == TA + TH + TS) ? t.rf : t.re;
            else
                RTC_out = 8'($urandom_range(0, 255));
            if (pulse && k == TA + TH + 2) begin
                req = 1'b1; we = ~t.we; addr = 8'hFF; wdata = 8'h00;
            end
            if (pulse && k == TA + TH + 3) req = 1'b0;
            if (chain && k == TOTAL + 1) begin
                req = 1'b1; we = nt.we; addr = nt.addr; wdata = nt.wdata;
            end
            @(negedge clk);
            check_bus($sformatf("%s_cyc%0d", name, k), exp_bus(k, t));
            if (k == TOTAL + 1) check_val({name, "_rdata"}, rdata, exp_rd);
            @(posedge clk);
            #1;
        end
        req = 1'b0;
    endtask

    task automatic check_idle(input string name, input logic [7:0] exp_rd);
        bus_t ib;
        ib = '{a_d: 1'b1, cs: 1'b1, rd: 1'b1, wr: 1'b1, oe: 1'b0, rtc_in: 8'h00, busy: 1'b0, done: 1'b0};
        check_bus(name, ib);
        check_val({name, "_rdata"}, rdata, exp_rd);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        txn_t none;
        none = '{we: 1'b0, addr: 8'h00, wdata: 8'h00, rf: 8'h00, re: 8'h00};

        vecs[0] = '{t: '{we: 1'b1, addr: 8'h21, wdata: 8'h45, rf: 8'h00, re: 8'h00}, exp_rdata: 8'h00};
        vecs[1] = '{t: '{we: 1'b0, addr: 8'h22, wdata: 8'h00, rf: 8'hAD, re: 8'hAD}, exp_rdata: 8'hAD};
        vecs[2] = '{t: '{we: 1'b0, addr: 8'h30, wdata: 8'h99, rf: 8'h5A, re: 8'h11}, exp_rdata: 8'h5A};
        vecs[3] = '{t: '{we: 1'b1, addr: 8'h0F, wdata: 8'hC3, rf: 8'h77, re: 8'h66}, exp_rdata: 8'h5A};

        reset = 1'b0; req = 1'b0; we = 1'b0; addr = 8'h00; wdata = 8'h00; RTC_out = 8'h00;
        #12;
        check_idle("reset_initial", 8'h00);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check_idle("post_reset_idle", 8'h00);
        @(posedge clk);
        #1;

        // Write with full timing trace, then a read with a request pulse during DATA.
        launch(vecs[0].t);
        run_body("write21", vecs[0].t, vecs[0].exp_rdata, 1'b0, 1'b0, none);
        launch(vecs[1].t);
        run_body("read22_pulse", vecs[1].t, vecs[1].exp_rdata, 1'b1, 1'b0, none);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_idle($sformatf("after_ignored_req%0d", i), 8'hAD);
        end
        @(posedge clk);
        #1;

        // Last-strobe-cycle sampling, then a write chained into the done cycle.
        launch(vecs[2].t);
        run_body("read30_last", vecs[2].t, vecs[2].exp_rdata, 1'b0, 1'b1, vecs[3].t);
        run_body("write0f_b2b", vecs[3].t, vecs[3].exp_rdata, 1'b0, 1'b0, none);
        rd_model = 8'h5A;

        // Reset in the middle of a write's DATA phase.
        launch(vecs[3].t);
        repeat (TA + TH + 1) @(posedge clk);
        #3;
        check_val("pre_reset_wr_low", {7'd0, WR}, 8'h00);
        reset = 1'b0;
        #1;
        check_idle("midreset_pins", 8'h00);
        rd_model = 8'h00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_idle($sformatf("held_reset%0d", i), 8'h00);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        begin
            txn_t fresh;
            fresh = '{we: 1'b0, addr: 8'h40, wdata: 8'h00, rf: 8'h3C, re: 8'hE1};
            launch(fresh);
            run_body("fresh_read", fresh, 8'h3C, 1'b0, 1'b0, none);
            rd_model = 8'h3C;
        end

        // Random transactions against the model; chaining and stray pulses chosen at random.
        for (int i = 0; i < NRAND; i++) begin
            rtx[i].we    = 1'($urandom_range(0, 1));
            rtx[i].addr  = 8'($urandom_range(0, 255));
            rtx[i].wdata = 8'($urandom_range(0, 255));
            rtx[i].rf    = 8'($urandom_range(0, 255));
            rtx[i].re    = 8'($urandom_range(0, 255));
        end
        launch(rtx[0]);
        for (int i = 0; i < NRAND; i++) begin
            bit chain;
            bit pulse;
            chain = (i < NRAND - 1) && ($urandom_range(0, 1) == 1);
            pulse = ($urandom_range(0, 3) == 0);
            if (!rtx[i].we) rd_model = rtx[i].rf;
            exp_q.push_back(rd_model);
            run_body($sformatf("rand%0d", i), rtx[i], exp_q.pop_front(), pulse, chain,
                     (i < NRAND - 1) ? rtx[i + 1] : none);
            if (!chain && i < NRAND - 1) begin
                @(negedge clk);
                check_idle($sformatf("rand_gap%0d", i), rd_model);
                @(posedge clk);
                #1;
                launch(rtx[i + 1]);
            end
        end
        @(negedge clk);
        check_idle("final_idle", rd_model);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
